// File: rtl/readback_pkg.sv
// Shared definitions for the register readback parallel-to-serial bridge.
// State encoding and default word width.
package readback_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

endpackage : readback_pkg

// File: rtl/piso_shift_reg.sv
// WIDTH-bit load/shift register with MSB tap; all updates gated by the global enable.
// Shifts left with zero fill so the MSB is always the next bit to leave.
module piso_shift_reg
  import readback_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = din_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else if (en_i) begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule : piso_shift_reg

// File: rtl/reg_readback_piso.sv
// Captures a parallel word and streams it out MSB first over a valid/ready link.
// Define READBACK_PARITY_EN to append an even-parity bit after the data bits.
//
//   state | meaning
//   IDLE  | waiting for a capture; cap_ready high once enabled out of reset
//   SHIFT | presenting data bit cnt (MSB first), advancing on ser_ready
//   PAR   | presenting the parity bit of the captured word (parity build only)
module reg_readback_piso
  import readback_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cap_valid,
  output logic             cap_ready,
  input  logic [WIDTH-1:0] cap_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cap_ready_q;
  logic             shreg_msb;
  logic             capture;
  logic             shift_go;
  logic             cnt_last;
`ifdef READBACK_PARITY_EN
  logic             parity_q;
`endif

  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));
  assign capture  = (state_q == IDLE) && cap_valid && cap_ready_q && enable;
  assign shift_go = (state_q == SHIFT) && ser_ready;

  piso_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (enable),
    .load_i (capture),
    .shift_i(shift_go),
    .din_i  (cap_data),
    .msb_o  (shreg_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_ready_q <= 1'b0;
`ifdef READBACK_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q     <= SHIFT;
            cnt_q       <= '0;
            cap_ready_q <= 1'b0;
`ifdef READBACK_PARITY_EN
            parity_q    <= ^cap_data;
`endif
          end else begin
            cap_ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (cnt_last) begin
              cnt_q <= '0;
`ifdef READBACK_PARITY_EN
              state_q <= PAR;
`else
              state_q     <= IDLE;
              cap_ready_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef READBACK_PARITY_EN
        PAR: begin
          if (ser_ready) begin
            state_q     <= IDLE;
            cap_ready_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          cap_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Serial bit and frame marker decode from held state only, never from ready/valid inputs.
  always_comb begin
    ser_out  = 1'b0;
    ser_last = 1'b0;
    case (state_q)
      SHIFT: begin
        ser_out = shreg_msb;
`ifndef READBACK_PARITY_EN
        ser_last = cnt_last;
`endif
      end
`ifdef READBACK_PARITY_EN
      PAR: begin
        ser_out  = parity_q;
        ser_last = 1'b1;
      end
`endif
      default: begin
        ser_out  = 1'b0;
        ser_last = 1'b0;
      end
    endcase
  end

  assign cap_ready = cap_ready_q;
  assign ser_valid = (state_q != IDLE);
  assign busy      = (state_q != IDLE);

endmodule : reg_readback_piso

// File: tb/tb_reg_readback_piso.sv
// Directed and randomized checks of reg_readback_piso at WIDTH=8 against a frame model.
// Honours READBACK_PARITY_EN to expect the extra parity bit.
module tb_reg_readback_piso;

  localparam int W = 8;
`ifdef READBACK_PARITY_EN
  localparam int LEN = W + 1;
`else
  localparam int LEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         cap_valid;
  logic         cap_ready;
  logic [W-1:0] cap_data;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_out;
  logic         ser_last;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  reg_readback_piso #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cap_valid(cap_valid),
    .cap_ready(cap_ready),
    .cap_data (cap_data),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_out  (ser_out),
    .ser_last (ser_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: data bits MSB first, then (optionally) even parity of the word.
  function automatic logic exp_bit(input logic [W-1:0] w, input int idx);
    int ones;
    if (idx < W) return logic'((int'(w) >> (W - 1 - idx)) % 2);
    ones = 0;
    for (int i = 0; i < W; i++) ones += (int'(w) >> i) % 2;
    return logic'(ones % 2);
  endfunction

  // Called at a negedge; returns at the negedge following the capturing edge.
  task automatic capture(input logic [W-1:0] w);
    int budget;
    budget = 0;
    enable = 1'b1;
    while (cap_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("cap_ready_wait", cap_ready, 1'b1);
    cap_data  = w;
    cap_valid = 1'b1;
    @(negedge clk);
    cap_valid = 1'b0;
  endtask

  task automatic stream(input logic [W-1:0] w, input int stall_at, input int stall_len,
                        input int freeze_at, input int freeze_len, input bit rnd,
                        input int exp_cycles);
    int idx, cyc, s_cnt, f_cnt;
    logic rdy, en;
    idx = 0; cyc = 0; s_cnt = 0; f_cnt = 0;
    while (idx < LEN && cyc < 300) begin
      rdy = 1'b1;
      en  = 1'b1;
      if (rnd) begin
        rdy = ($urandom_range(0, 99) >= 30);
        en  = ($urandom_range(0, 99) >= 15);
      end else if (idx == stall_at && s_cnt < stall_len) begin
        rdy = 1'b0;
        s_cnt++;
      end else if (idx == freeze_at && f_cnt < freeze_len) begin
        en = 1'b0;
        f_cnt++;
      end
      ser_ready = rdy;
      enable    = en;
      check($sformatf("ser_valid[%0h/%0d]", w, idx), ser_valid, 1'b1);
      check($sformatf("ser_out[%0h/%0d]", w, idx), ser_out, exp_bit(w, idx));
      check($sformatf("ser_last[%0h/%0d]", w, idx), ser_last, (idx == LEN - 1));
      check($sformatf("cap_ready_busy[%0h/%0d]", w, idx), cap_ready, 1'b0);
      if (rdy && en) idx++;
      cyc++;
      @(negedge clk);
    end
    check($sformatf("frame_done[%0h]", w), idx, LEN);
    if (exp_cycles > 0) check($sformatf("frame_cycles[%0h]", w), cyc, exp_cycles);
    enable    = 1'b1;
    ser_ready = 1'b1;
    check($sformatf("end_cap_ready[%0h]", w), cap_ready, 1'b1);
    check($sformatf("end_ser_valid[%0h]", w), ser_valid, 1'b0);
    check($sformatf("end_busy[%0h]", w), busy, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rw;
    rst_n = 1'b0; enable = 1'b1; cap_valid = 1'b0; cap_data = '0; ser_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cap_ready", cap_ready, 1'b0);
    check("rst_ser_valid", ser_valid, 1'b0);
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_ser_last", ser_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    check("pre_edge_cap_ready", cap_ready, 1'b0);
    @(negedge clk);
    check("post_rst_cap_ready", cap_ready, 1'b1);

    // Basic frame at full ready: exactly LEN transfer cycles
    capture(8'hA5);
    stream(8'hA5, -1, 0, -1, 0, 1'b0, LEN);

    // Sink stall after two bits
    capture(8'hC3);
    stream(8'hC3, 2, 3, -1, 0, 1'b0, LEN + 3);

    // Global enable freeze mid-frame
    capture(8'hF0);
    stream(8'hF0, -1, 0, 3, 4, 1'b0, LEN + 4);

    // Mid-frame reset discards the partial frame
    capture(8'hFF);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ff_bit%0d", i), ser_out, 1'b1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ser_valid", ser_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cap_ready", cap_ready, 1'b0);
    check("midrst_ser_out", ser_out, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", cap_ready, 1'b1);
    capture(8'h01);
    stream(8'h01, -1, 0, -1, 0, 1'b0, LEN);

    // Capture request while busy must wait for cap_ready
    capture(8'h81);
    cap_data  = 8'h00;
    cap_valid = 1'b1;
    stream(8'h81, -1, 0, -1, 0, 1'b0, LEN);
    capture(8'h00);
    stream(8'h00, -1, 0, -1, 0, 1'b0, LEN);

    // Parity-sensitive words, then randomized traffic
    capture(8'h07);
    stream(8'h07, -1, 0, -1, 0, 1'b0, LEN);
    capture(8'h03);
    stream(8'h03, -1, 0, -1, 0, 1'b0, LEN);
    for (int k = 0; k < 8; k++) begin
      rw = W'($urandom);
      capture(rw);
      stream(rw, -1, 0, -1, 0, 1'b1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_readback_piso
